pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// This is one pipeline register stage with a valid/ready handshake on both
// sides. A flush or csr_flush turns the stage into an injected NOP bubble.
// A stall freezes the stage.
//
// The optional skid entry is enabled by the PIPE_STAGE_SKID_EN macro.
//   - Defined:   there is one extra skid entry. in_ready is taken from
//                registers only, so there is no combinational path from
//                out_ready. The stage sustains 1 entry per cycle.
//   - Undefined: there is no skid storage. in_ready depends combinationally
//                on out_ready.
//
// Parameters
//   ADDR_W     address payload width
//   INST_W     instruction payload width
//   NOP_INST   instruction injected on a flush (addi x0,x0,0)
//   RESET_INST value of out_inst after reset
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready/in_addr/in_inst upstream handshake and payload
//   stall                             freezes the stage and blocks input
//   flush, csr_flush                  replace the contents with a NOP bubble
//   out_valid/out_ready               downstream handshake
//   out_addr/out_inst                 downstream payload
//   out_bubble                        current entry is an injected NOP
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter logic [INST_W-1:0] NOP_INST   = INST_W'(32'h00000013),
   parameter logic [INST_W-1:0] RESET_INST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [INST_W-1:0] in_inst,
   input  logic              stall,
   input  logic              flush,
   input  logic              csr_flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [INST_W-1:0] out_inst,
   output logic              out_bubble
);

   logic              out_valid_reg;
   logic              out_bubble_reg;
   logic [ADDR_W-1:0] out_addr_reg;
   logic [INST_W-1:0] out_inst_reg;

   logic              accept;
   logic              drain;
   logic              load_main;
   logic              any_flush;

   // The main register loads from src_*.
   logic              src_valid;
   logic [ADDR_W-1:0] src_addr;
   logic [INST_W-1:0] src_inst;

   assign accept    = in_valid && in_ready;
   assign drain     = out_valid_reg && out_ready && !stall;
   assign load_main = !out_valid_reg || drain;
   assign any_flush = flush || csr_flush;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid_reg;
   logic [ADDR_W-1:0] skid_addr_reg;
   logic [INST_W-1:0] skid_inst_reg;

   // in_ready comes from registers only. It is low whenever the skid entry
   // is full, so an accept can never collide with a pending skid entry.
   assign in_ready = !skid_valid_reg && !stall;

   // Entries leave in order: an older skid entry goes to the main register
   // before any new input.
   assign src_valid = skid_valid_reg || accept;
   assign src_addr  = skid_valid_reg ? skid_addr_reg : in_addr;
   assign src_inst  = skid_valid_reg ? skid_inst_reg : in_inst;

   always_ff @(posedge clk) begin
      if (rst || any_flush) begin
         skid_valid_reg <= 1'b0;
      end else if (!stall) begin
         if (load_main) begin
            // The main register takes the skid entry, or the input directly.
            skid_valid_reg <= 1'b0;
         end else if (accept) begin
            // The main register is occupied and not draining, so park the input.
            skid_valid_reg <= 1'b1;
            skid_addr_reg  <= in_addr;
            skid_inst_reg  <= in_inst;
         end
      end
   end
`else
   // Without skid storage, input is only taken when the main register can
   // load it in the same cycle.
   assign in_ready  = (!out_valid_reg || out_ready) && !stall;

   assign src_valid = accept;
   assign src_addr  = in_addr;
   assign src_inst  = in_inst;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         out_bubble_reg <= 1'b0;
         out_addr_reg   <= '0;
         out_inst_reg   <= RESET_INST;
      end else if (any_flush) begin
         // Flush wins over stall. The address is kept so the bubble still
         // carries the PC of the squashed slot.
         out_valid_reg  <= 1'b1;
         out_bubble_reg <= 1'b1;
         out_inst_reg   <= NOP_INST;
      end else if (!stall && load_main) begin
         if (src_valid) begin
            out_valid_reg  <= 1'b1;
            out_bubble_reg <= 1'b0;
            out_addr_reg   <= src_addr;
            out_inst_reg   <= src_inst;
         end else begin
            out_valid_reg  <= 1'b0;
         end
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_bubble = out_bubble_reg;
   assign out_addr   = out_addr_reg;
   assign out_inst   = out_inst_reg;

endmodule
